// File: rtl/unidade_load_store.sv
// Load/store sequencer between the core memory stage and a word-only data memory.
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended.
module unidade_load_store #(
  parameter int unsigned IDX_W           = 10,
  parameter bit          ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_wr,
  input  logic [31:0] mem_rd
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_ERR,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wd_q, mem_wd_d;
  logic                mem_wr_q, mem_wr_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic [HALF_W-1:0]   wlo_q, wlo_d;

  logic                is_half_c;
  logic                is_word_c;
  logic                legal_c;
  logic                misal_c;
  logic                unused_addr_hi;

  // Word-index bits above IDX_W never reach the memory.
  assign unused_addr_hi = ^addr[31:IDX_W+2];

  // Select the addressed lane of a read word and extend it to 32 bits.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        off,
    input logic [2:0]        f3
  );
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;
    b = BYTE_W'(w >> {off, 3'b000});
    h = HALF_W'(w >> {off[1], 4'b0000});
    case (f3)
      F_B:     return {{(DATA_W-BYTE_W){b[BYTE_W-1]}}, b};
      F_H:     return {{(DATA_W-HALF_W){h[HALF_W-1]}}, h};
      F_BU:    return DATA_W'(b);
      F_HU:    return DATA_W'(h);
      default: return w;
    endcase
  endfunction

  // Overlay the store byte/half onto the word read back from memory.
  function automatic logic [DATA_W-1:0] store_merge(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        off,
    input logic [2:0]        f3,
    input logic [HALF_W-1:0] d
  );
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] v;
    if (f3[1:0] == 2'b01) begin
      m = DATA_W'(32'h0000_FFFF) << {off[1], 4'b0000};
      v = DATA_W'(d) << {off[1], 4'b0000};
    end else begin
      m = DATA_W'(32'h0000_00FF) << {off, 3'b000};
      v = DATA_W'(d[BYTE_W-1:0]) << {off, 3'b000};
    end
    return (w & ~m) | v;
  endfunction

  // Decode of the request currently presented on the inputs.
  always_comb begin
    is_half_c = (funct3[1:0] == 2'b01);
    is_word_c = (funct3[1:0] == 2'b10);
    if (we) begin
      legal_c = (funct3 == F_B) || (funct3 == F_H) || (funct3 == F_W);
    end else begin
      legal_c = (funct3 == F_B) || (funct3 == F_H) || (funct3 == F_W) ||
                (funct3 == F_BU) || (funct3 == F_HU);
    end
    misal_c = (is_half_c && addr[0]) || (is_word_c && (addr[1:0] != 2'b00));
  end

  // Next state and next register values.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wd_d     = mem_wd_q;
    mem_wr_d     = 1'b0;
    funct3_d     = funct3_q;
    off_d        = off_q;
    wlo_d        = wlo_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          funct3_d = funct3;
          off_d    = addr[1:0];
          wlo_d    = wdata[HALF_W-1:0];
          if (!legal_c || (ERR_ON_MISALIGN && misal_c)) begin
            state_d = S_ERR;
          end else begin
            mem_addr_d = DATA_W'(addr[IDX_W+1:2]);
            if (!we) begin
              state_d = S_RD;
            end else if (funct3 == F_W) begin
              state_d  = S_WR;
              mem_wd_d = wdata;
              mem_wr_d = 1'b1;
            end else begin
              state_d = S_RMW_RD;
            end
          end
        end
      end
      S_RD: begin
        rdata_d      = load_extract(mem_rd, off_q, funct3_q);
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RMW_RD: begin
        mem_wd_d = store_merge(mem_rd, off_q, funct3_q, wlo_q);
        mem_wr_d = 1'b1;
        state_d  = S_WR;
      end
      S_WR: begin
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        err_d        = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // Async reset clears mem_wr immediately since the memory writes on level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wd_q     <= '0;
      mem_wr_q     <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      wlo_q        <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wd_q     <= mem_wd_d;
      mem_wr_q     <= mem_wr_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      wlo_q        <= wlo_d;
    end
  end

  assign ready      = ready_q;
  assign resp_valid = resp_valid_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wd     = mem_wd_q;
  assign mem_wr     = mem_wr_q;

endmodule
